// File: rtl/draw_seq_pkg.sv
// Shared types and helpers for the draw phase sequencer.
package draw_seq_pkg;

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_CHECK     = 3'd1,
        ST_COMP_HOLD = 3'd2,
        ST_SEL       = 3'd3,
        ST_SEL_HOLD  = 3'd4,
        ST_DONE      = 3'd5,
        ST_SKIP      = 3'd6
    } state_e;

    // Highest legal encoding; anything above it recovers to ST_RESET.
    localparam logic [2:0] ST_LAST = 3'd6;

    // Width of the shared hold/wait counter, sized for the largest load value.
    function automatic int cnt_width(input int comp_hold, input int sel_hold, input int wait_cycles);
        int m;
        m = 1;
        if (comp_hold > m) m = comp_hold;
        if (sel_hold > m) m = sel_hold;
        if (wait_cycles > m) m = wait_cycles;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/draw_phase_sequencer_if.sv
// Control/strobe bundle between the sequencer and the drawing datapath.
interface draw_phase_sequencer_if #(
    parameter int LAYER_W = 1
);
    logic               en;
    logic               is_pixel;
    logic               refresh_comp;
    logic               refresh_select;
    logic [LAYER_W-1:0] layer_idx;
    logic               pixel_done;
    logic               pixel_skip;
    logic               busy;

    modport master (
        output en, is_pixel,
        input  refresh_comp, refresh_select, layer_idx, pixel_done, pixel_skip, busy
    );

    modport slave (
        input  en, is_pixel,
        output refresh_comp, refresh_select, layer_idx, pixel_done, pixel_skip, busy
    );
endinterface

// File: rtl/draw_phase_sequencer_phase_counter.sv
// Loadable down-counter that stops at zero; shared by all hold and wait phases.
module phase_counter #(
    parameter int CNT_W = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Load has priority over decrement; the count never wraps below zero.
    always_comb begin
        count_d = count_q;
        if (en) begin
            if (load) begin
                count_d = load_val;
            end else if (count_q != '0) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/draw_phase_sequencer.sv
// Per-pixel compare/select strobe sequencer with per-layer select phases.
module draw_phase_sequencer
    import draw_seq_pkg::*;
#(
    parameter int NUM_LAYERS  = 1,
    parameter int COMP_HOLD   = 1,
    parameter int SEL_HOLD    = 1,
    parameter int WAIT_CYCLES = 4,
    parameter int LAYER_W     = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    draw_phase_sequencer_if.slave sif
);

    localparam int CNT_W = cnt_width(COMP_HOLD, SEL_HOLD, WAIT_CYCLES);

    state_e             state_q, state_d;
    logic [LAYER_W-1:0] layer_q, layer_d;
    logic               comp_q, comp_d;
    logic               sel_q, sel_d;
    logic               done_q, done_d;
    logic               skip_q, skip_d;
    logic               busy_q, busy_d;
    logic               cnt_load;
    logic [CNT_W-1:0]   cnt_val;
    logic               cnt_zero;

    phase_counter #(
        .CNT_W (CNT_W)
    ) u_phase_counter (
        .clk      (clk),
        .reset    (reset),
        .en       (sif.en),
        .load     (cnt_load),
        .load_val (cnt_val),
        .zero     (cnt_zero)
    );

    // Next state, layer and counter loads; everything holds while en is low.
    always_comb begin
        state_d  = state_q;
        layer_d  = layer_q;
        cnt_load = 1'b0;
        cnt_val  = '0;
        skip_d   = skip_q;
        if (sif.en) begin
            skip_d = 1'b0;
            case (state_q)
                ST_RESET: state_d = ST_CHECK;
                ST_CHECK: begin
                    if (sif.is_pixel) begin
                        state_d  = ST_COMP_HOLD;
                        cnt_load = 1'b1;
                        cnt_val  = CNT_W'(COMP_HOLD - 1);
                    end else begin
                        // The skip pulse lands in the cycle after the compare,
                        // whether that cycle is SKIP or another CHECK.
                        skip_d = 1'b1;
                        if (WAIT_CYCLES == 0) begin
                            state_d = ST_CHECK;
                        end else begin
                            state_d  = ST_SKIP;
                            cnt_load = 1'b1;
                            cnt_val  = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;
                        end
                    end
                end
                ST_COMP_HOLD: begin
                    if (cnt_zero) begin
                        state_d = ST_SEL;
                        layer_d = '0;
                    end
                end
                ST_SEL: begin
                    state_d  = ST_SEL_HOLD;
                    cnt_load = 1'b1;
                    cnt_val  = CNT_W'(SEL_HOLD - 1);
                end
                ST_SEL_HOLD: begin
                    if (cnt_zero) begin
                        if (layer_q != LAYER_W'(NUM_LAYERS - 1)) begin
                            layer_d = layer_q + LAYER_W'(1);
                            state_d = ST_SEL;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    layer_d = '0;
                    state_d = ST_CHECK;
                end
                ST_SKIP: begin
                    if (cnt_zero) state_d = ST_CHECK;
                end
                default: begin
                    state_d = ST_RESET;
                    layer_d = '0;
                end
            endcase
        end
        if (state_q > ST_LAST) begin
            state_d = ST_RESET;
            layer_d = '0;
            skip_d  = 1'b0;
        end
    end

    // Moore output flags decoded from the next state so they register with it.
    always_comb begin
        comp_d = (state_d == ST_CHECK);
        sel_d  = (state_d == ST_SEL);
        done_d = (state_d == ST_DONE);
        busy_d = !((state_d == ST_RESET) || (state_d == ST_CHECK));
    end

    // State, layer and registered output flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RESET;
            layer_q <= '0;
            comp_q  <= 1'b0;
            sel_q   <= 1'b0;
            done_q  <= 1'b0;
            skip_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            layer_q <= layer_d;
            comp_q  <= comp_d;
            sel_q   <= sel_d;
            done_q  <= done_d;
            skip_q  <= skip_d;
            busy_q  <= busy_d;
        end
    end

    // Strobes are suppressed while stalled so each fires once on resume.
    assign sif.refresh_comp   = comp_q & sif.en;
    assign sif.refresh_select = sel_q & sif.en;
    assign sif.pixel_done     = done_q & sif.en;
    assign sif.pixel_skip     = skip_q & sif.en;
    assign sif.layer_idx      = layer_q;
    assign sif.busy           = busy_q;

endmodule
